ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS-subset pipeline. Consumes the ID/EX pipeline register
//  outputs, computes ALU result or memory address, and registers results into EX/MEM.
//  Holds a sequential shift-add unsigned multiplier (MULTU -> HI/LO).
//  Raises stall_out upstream while the multiplier is busy.
// PARAMETERS
//  WIDTH  32  datapath width; multiplier runs WIDTH iterations
//  REGW   5   register-index width
// PORTS
//  clock          in   1      sole clock; all state updates on posedge
//  reset          in   1      synchronous, active-high
//  valid_in       in   1      ID/EX holds a real instruction (0 = bubble)
//  RS_in          in   WIDTH  rs operand value
//  RT_in          in   WIDTH  rt operand value
//  RD_in          in   REGW   rd index
//  instr_in       in   32     raw instruction word
//  jump_in        in   1      instruction is a jump (resolved in ID)
//  reg_write_in   in   1      instruction writes the register file
//  reg_dst_in     in   1      1 = dest is RD_in, 0 = dest is instr_in[20:16]
//  mem_dst_in     in   1      result destined for memory (lw/sw)
//  stall_out      out  1      upstream must hold IF/ID and ID/EX contents
//  valid_out      out  1      EX/MEM holds a retired instruction
//  ALU_out        out  WIDTH  ALU result or effective address
//  RT_out         out  WIDTH  store data (registered RT_in)
//  dest_out       out  REGW   destination register index
//  reg_write_out  out  1      qualified register write enable
//  mem_dst_out    out  1      registered mem_dst_in
//  hi_out, lo_out out  WIDTH  HI/LO architectural registers
// BEHAVIOUR
//  Reset: all outputs 0, HI = LO = 0, FSM = IDLE. Reset mid-multiply aborts; HI/LO are not
//    written. stall_out is 0 in the cycle after the reset edge.
//  Decode: op = instr_in[31:26], funct = [5:0], shamt = [10:6], imm = [15:0].
//  R-type (op 0): 20 add, 22 sub, 24 and, 25 or, 2A slt (signed), 00 sll, 02 srl (by shamt, on RT),
//    10 mfhi, 12 mflo, 19 multu.
//  I-type: 08 addi (sign-extended imm), 0C andi / 0D ori (zero-extended imm),
//    23 lw / 2B sw (ALU_out = RS + sext(imm)).
//  Add, sub and addi wrap modulo 2^WIDTH; no overflow trap.
//  dest_out = reg_dst_in ? RD_in : instr_in[20:16].
//  reg_write_out = valid & reg_write_in & (dest != 0) & known opcode.
//  Unknown opcode/funct: ALU_out = 0, reg_write_out = 0, valid_out = 1.
//  jump_in = 1: retires with reg_write_out = 0, ALU_out = 0.
//  Latency: non-multu instructions take 1 cycle. All outputs are registered on the posedge
//    where stall_out = 0.
//  Bubble: valid_in = 0 or stall_out = 1 -> valid_out <= 0, reg_write_out <= 0 (other fields don't-care, held).
//  Multiplier FSM {IDLE, MUL, DONE}:
//    IDLE: valid_in & multu -> load operands, count = 0, go MUL.
//      stall_out = 1 combinationally in this cycle.
//    MUL: one shift-add step per cycle; stall_out = 1. When count == WIDTH-1:
//      write {HI,LO} = RS*RT (unsigned, 2*WIDTH bits), go DONE.
//    DONE: stall_out = 0. The held multu retires this edge (valid_out = 1, reg_write_out = 0).
//      Always go IDLE. The re-presented multu is never restarted.
//    Total: stall_out high for WIDTH+1 cycles, then the instruction retires.
//  mfhi/mflo immediately after multu read the new HI/LO (no hazard bubble needed).
//  While stalled, RS_in/RT_in are ignored; operands are taken only from the IDLE load.
// STRUCTURE
//  Package ex_pkg: opcode/funct localparams, FSM state enum, WIDTH/REGW defaults.
//  Sub-module mul_seq: iterative shift-add multiplier.
//    Ports: start, a, b, busy, done, product[2*WIDTH-1:0].
//  ALU decode and EX/MEM register stay in ex_stage.
// TESTING
//  add: RS=5, RT=7, funct 20, RD=3 -> next cycle ALU_out=12, dest_out=3, reg_write_out=1, valid_out=1.
//  slt: RS=FFFFFFFF, RT=1 -> ALU_out=1; sub 0-1 -> FFFFFFFF (wrap); sll shamt 4 of 1 -> 10.
//  multu: RS=FFFFFFFF, RT=2 -> stall_out high exactly 33 cycles; HI=1, LO=FFFFFFFE;
//    one retire with reg_write_out=0; following mfhi -> ALU_out=1.
//  Reset 10 cycles into multu -> next cycle stall_out=0, valid_out=0, HI=LO=0;
//    a fresh add issues normally.
//  lw: RS=100, imm=FFFC -> ALU_out=FC, mem_dst_out=1.
//    addi targeting $0 -> reg_write_out=0. valid_in=0 -> valid_out=0.
//  Unknown op 3F with reg_write_in=1 -> reg_write_out=0, ALU_out=0;
//    jump_in=1 -> valid_out=1, reg_write_out=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and defaults for the MIPS-subset execute stage.
package ex_pkg;

  localparam int EX_WIDTH = 32;
  localparam int EX_REGW  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// the product register doubles as the architectural {HI,LO} pair.
module mul_seq
  import ex_pkg::*;
#(
  parameter int WIDTH = EX_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t           state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic                 last;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign last     = (count == CW'(WIDTH - 1));
  assign busy     = (state == ST_MUL);
  assign done     = (state == ST_DONE);

  // Product only changes on the final step, so an aborted multiply leaves HI/LO intact
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          count <= count + 1'b1;
          if (last) begin
            product <= acc_next;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU / address generation into the EX/MEM register, plus
// the multicycle MULTU unit that stalls upstream while it iterates.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = EX_WIDTH,
  parameter int REGW  = EX_REGW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] RS_in,
  input  logic [WIDTH-1:0] RT_in,
  input  logic [REGW-1:0]  RD_in,
  input  logic [31:0]      instr_in,
  input  logic             jump_in,
  input  logic             reg_write_in,
  input  logic             reg_dst_in,
  input  logic             mem_dst_in,
  output logic             stall_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] RT_out,
  output logic [REGW-1:0]  dest_out,
  output logic             reg_write_out,
  output logic             mem_dst_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  function automatic logic [WIDTH-1:0] sext16(input logic [15:0] v);
    return {{(WIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] zext16(input logic [15:0] v);
    return {{(WIDTH-16){1'b0}}, v};
  endfunction

  logic [5:0]              op;
  logic [5:0]              funct;
  logic [4:0]              shamt;
  logic [15:0]             imm;
  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic                    unused_rs_field;

  assign op              = instr_in[31:26];
  assign funct           = instr_in[5:0];
  assign shamt           = instr_in[10:6];
  assign imm             = instr_in[15:0];
  assign rs_s            = RS_in;
  assign rt_s            = RT_in;
  assign unused_rs_field = ^instr_in[25:21];

  logic [2*WIDTH-1:0] product;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_start;
  logic               is_multu;

  assign hi_out = product[2*WIDTH-1:WIDTH];
  assign lo_out = product[WIDTH-1:0];

  assign is_multu  = (op == OP_RTYPE) && (funct == FN_MULTU);
  // The multu re-presented during DONE retires instead of restarting
  assign mul_start = valid_in && is_multu && !mul_busy && !mul_done;
  assign stall_out = mul_start || mul_busy;

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (RS_in),
    .b       (RT_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  logic [WIDTH-1:0] alu_res;
  logic             known;
  logic             writes;
  logic [REGW-1:0]  dest;
  logic             wr_en;

  always_comb begin
    alu_res = '0;
    known   = 1'b1;
    writes  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:   alu_res = RS_in + RT_in;
          FN_SUB:   alu_res = RS_in - RT_in;
          FN_AND:   alu_res = RS_in & RT_in;
          FN_OR:    alu_res = RS_in | RT_in;
          FN_SLT:   alu_res = (rs_s < rt_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
          FN_SLL:   alu_res = RT_in << shamt;
          FN_SRL:   alu_res = RT_in >> shamt;
          FN_MFHI:  alu_res = hi_out;
          FN_MFLO:  alu_res = lo_out;
          FN_MULTU: writes  = 1'b0;
          default:  known   = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = RS_in + sext16(imm);
      OP_ANDI:               alu_res = RS_in & zext16(imm);
      OP_ORI:                alu_res = RS_in | zext16(imm);
      default:               known   = 1'b0;
    endcase
    if (!known || jump_in) alu_res = '0;
  end

  assign dest  = reg_dst_in ? RD_in : REGW'(instr_in[20:16]);
  assign wr_en = reg_write_in && known && writes && !jump_in && (dest != '0);

  // EX/MEM register: advances only on unstalled edges
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
      ALU_out       <= '0;
      RT_out        <= '0;
      dest_out      <= '0;
      mem_dst_out   <= 1'b0;
    end else if (stall_out || !valid_in) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
    end else begin
      valid_out     <= 1'b1;
      reg_write_out <= wr_en;
      ALU_out       <= alu_res;
      RT_out        <= RT_in;
      dest_out      <= dest;
      mem_dst_out   <= mem_dst_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors, randomized ALU traffic against an
// arithmetic reference, MULTU timing and HI/LO, and reset during a multiply.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in, jump_in, reg_write_in, reg_dst_in, mem_dst_in;
  logic [31:0] RS_in, RT_in, instr_in;
  logic [4:0]  RD_in;
  logic        stall_out, valid_out, reg_write_out, mem_dst_out;
  logic [31:0] ALU_out, RT_out, hi_out, lo_out;
  logic [4:0]  dest_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .RS_in(RS_in), .RT_in(RT_in),
    .RD_in(RD_in), .instr_in(instr_in), .jump_in(jump_in), .reg_write_in(reg_write_in),
    .reg_dst_in(reg_dst_in), .mem_dst_in(mem_dst_in), .stall_out(stall_out),
    .valid_out(valid_out), .ALU_out(ALU_out), .RT_out(RT_out), .dest_out(dest_out),
    .reg_write_out(reg_write_out), .mem_dst_out(mem_dst_out), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic        v;
    logic [31:0] ins, a, b;
    logic [4:0]  rd;
    logic        rdst, rw, md, jmp;
    logic [31:0] e_alu;
    logic [4:0]  e_dst;
    logic        e_wr, e_v;
  } vec_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Reference: instruction semantics evaluated with 64-bit integer arithmetic
  function automatic void ref_ex(input logic [31:0] ins, a, b, hi, lo, input logic jmp,
                                 output logic [31:0] res, output logic wrk);
    logic [63:0] m, ua, ub, r, im;
    longint      sa, sb, simm, t;
    int          sh;
    logic        known;
    m    = 64'h1_0000_0000;
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    im   = {48'h0, ins[15:0]};
    sa   = a[31] ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = b[31] ? longint'(ub) - longint'(m) : longint'(ub);
    simm = ins[15] ? longint'(im) - 65536 : longint'(im);
    t    = longint'(ua) + simm;
    if (t < 0) t = t + longint'(m);
    sh    = int'(ins[10:6]);
    known = 1'b1;
    wrk   = 1'b1;
    r     = 64'd0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20:   r = (ua + ub) % m;
        6'h22:   r = (ua + m - ub) % m;
        6'h24:   r = ua & ub;
        6'h25:   r = ua | ub;
        6'h2A:   r = (sa < sb) ? 64'd1 : 64'd0;
        6'h00:   r = (ub * (64'd1 << sh)) % m;
        6'h02:   r = ub / (64'd1 << sh);
        6'h10:   r = {32'h0, hi};
        6'h12:   r = {32'h0, lo};
        6'h19:   wrk = 1'b0;
        default: known = 1'b0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h23, 6'h2B: r = 64'(t) % m;
        6'h0C:   r = ua & im;
        6'h0D:   r = ua | im;
        default: known = 1'b0;
      endcase
    end
    if (!known) wrk = 1'b0;
    res = (known && !jmp) ? r[31:0] : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, a, b, input logic [4:0] rd,
                       input logic rdst, rw, md, jmp);
    valid_in = v; instr_in = ins; RS_in = a; RT_in = b; RD_in = rd;
    reg_dst_in = rdst; reg_write_in = rw; mem_dst_in = md; jump_in = jmp;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    total++; if (reg_write_out !== 1'b0) begin bad++; $display("FAIL reset reg_write_out: got %b want 0", reg_write_out); end
    total++; if (ALU_out !== 32'd0) begin bad++; $display("FAIL reset ALU_out: got %h want 0", ALU_out); end
    total++; if (dest_out !== 5'd0 || RT_out !== 32'd0 || mem_dst_out !== 1'b0) begin
      bad++; $display("FAIL reset fields: got dest=%h rt=%h md=%b want 0", dest_out, RT_out, mem_dst_out); end
    total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      bad++; $display("FAIL reset hilo: got %h/%h want 0/0", hi_out, lo_out); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL reset stall_out: got %b want 0", stall_out); end
  endtask

  task automatic test_alu_directed();
    vec_t vt[12];
    vt[0]  = '{1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd12, 5'd3, 1'b1, 1'b1};
    vt[1]  = '{1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 5'd4, 1'b1, 1'b1};
    vt[2]  = '{1'b1, rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h22), 32'd0, 32'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b1};
    vt[3]  = '{1'b1, rtype(5'd0, 5'd2, 5'd6, 5'd4, 6'h00), 32'h1234, 32'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 5'd6, 1'b1, 1'b1};
    vt[4]  = '{1'b1, itype(6'h23, 5'd1, 5'd8, 16'hFFFC), 32'h100, 32'hDEAD, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFC, 5'd8, 1'b1, 1'b1};
    vt[5]  = '{1'b1, itype(6'h08, 5'd1, 5'd0, 16'h0005), 32'd10, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'd15, 5'd0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, itype(6'h3F, 5'd1, 5'd7, 16'h1234), 32'd9, 32'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd7, 1'b0, 1'b1};
    vt[8]  = '{1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 5'd3, 1'b0, 1'b1};
    vt[9]  = '{1'b1, rtype(5'd0, 5'd2, 5'd7, 5'd8, 6'h02), 32'd0, 32'hABCD1234, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00ABCD12, 5'd7, 1'b1, 1'b1};
    vt[10] = '{1'b1, itype(6'h0C, 5'd1, 5'd9, 16'hFF00), 32'hFFFF1234, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00001200, 5'd9, 1'b1, 1'b1};
    vt[11] = '{1'b1, itype(6'h0D, 5'd1, 5'd10, 16'h8001), 32'h10000000, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10008001, 5'd10, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].ins, vt[i].a, vt[i].b, vt[i].rd, vt[i].rdst, vt[i].rw, vt[i].md, vt[i].jmp);
      tick();
      total++; if (valid_out !== vt[i].e_v) begin bad++; $display("FAIL dir[%0d] valid_out: got %b want %b", i, valid_out, vt[i].e_v); end
      total++; if (reg_write_out !== vt[i].e_wr) begin bad++; $display("FAIL dir[%0d] reg_write_out: got %b want %b", i, reg_write_out, vt[i].e_wr); end
      if (vt[i].e_v) begin
        total++; if (ALU_out !== vt[i].e_alu) begin bad++; $display("FAIL dir[%0d] ALU_out: got %h want %h", i, ALU_out, vt[i].e_alu); end
        total++; if (dest_out !== vt[i].e_dst) begin bad++; $display("FAIL dir[%0d] dest_out: got %0d want %0d", i, dest_out, vt[i].e_dst); end
        total++; if (mem_dst_out !== vt[i].md || RT_out !== vt[i].b) begin
          bad++; $display("FAIL dir[%0d] md/rt: got %b/%h want %b/%h", i, mem_dst_out, RT_out, vt[i].md, vt[i].b); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, a, b, e_alu;
    logic [4:0]  rsf, rtf, rdf, sh, rd, e_dst;
    logic [15:0] im;
    logic        v, jmp, rw, rdst, md, wrk, e_wr;
    int          k;
    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 14);
      rsf = 5'($urandom); rtf = 5'($urandom); rdf = 5'($urandom); sh = 5'($urandom);
      im = 16'($urandom);
      case (k)
        0:  ins = rtype(rsf, rtf, rdf, sh, 6'h20);
        1:  ins = rtype(rsf, rtf, rdf, sh, 6'h22);
        2:  ins = rtype(rsf, rtf, rdf, sh, 6'h24);
        3:  ins = rtype(rsf, rtf, rdf, sh, 6'h25);
        4:  ins = rtype(rsf, rtf, rdf, sh, 6'h2A);
        5:  ins = rtype(rsf, rtf, rdf, sh, 6'h00);
        6:  ins = rtype(rsf, rtf, rdf, sh, 6'h02);
        7:  ins = rtype(rsf, rtf, rdf, sh, 6'h10);
        8:  ins = rtype(rsf, rtf, rdf, sh, 6'h12);
        9:  ins = itype(6'h08, rsf, rtf, im);
        10: ins = itype(6'h0C, rsf, rtf, im);
        11: ins = itype(6'h0D, rsf, rtf, im);
        12: ins = itype(6'h23, rsf, rtf, im);
        13: ins = itype(6'h2B, rsf, rtf, im);
        default: ins = ($urandom_range(0, 1) == 0) ? itype(6'h3F, rsf, rtf, im)
                                                   : rtype(rsf, rtf, rdf, sh, 6'h3F);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      v = ($urandom_range(0, 9) != 0);
      jmp = ($urandom_range(0, 9) == 0);
      rw = 1'($urandom); rdst = 1'($urandom); md = 1'($urandom); rd = 5'($urandom);
      ref_ex(ins, a, b, mdl_hi, mdl_lo, jmp, e_alu, wrk);
      e_dst = rdst ? rd : ins[20:16];
      e_wr  = v && rw && wrk && !jmp && (e_dst != 5'd0);
      drive(v, ins, a, b, rd, rdst, rw, md, jmp);
      tick();
      total++; if (valid_out !== v || reg_write_out !== e_wr) begin
        bad++; $display("FAIL rnd[%0d] valid/wr: got %b/%b want %b/%b ins=%h", it, valid_out, reg_write_out, v, e_wr, ins); end
      if (v) begin
        total++; if (ALU_out !== e_alu) begin
          bad++; $display("FAIL rnd[%0d] ALU_out: got %h want %h ins=%h a=%h b=%h", it, ALU_out, e_alu, ins, a, b); end
        total++; if (dest_out !== e_dst || RT_out !== b || mem_dst_out !== md) begin
          bad++; $display("FAIL rnd[%0d] dest/rt/md: got %0d/%h/%b want %0d/%h/%b", it, dest_out, RT_out, mem_dst_out, e_dst, b, md); end
      end
    end
  endtask

  task automatic test_multu();
    logic [31:0] ma[4], mb[4];
    logic [63:0] p;
    int n;
    ma[0] = 32'hFFFFFFFF; mb[0] = 32'd2;
    ma[1] = 32'hFFFFFFFF; mb[1] = 32'hFFFFFFFF;
    ma[2] = 32'd0;        mb[2] = 32'd12345;
    ma[3] = $urandom | 32'd1; mb[3] = $urandom | 32'd1;
    for (int i = 0; i < 4; i++) begin
      p = {32'h0, ma[i]} * {32'h0, mb[i]};
      drive(1'b1, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), ma[i], mb[i], 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      n = 0;
      while (stall_out === 1'b1 && n < 100) begin
        n++;
        tick();
        RS_in = $urandom; RT_in = $urandom;
        if (n == 2) begin
          total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mul[%0d] stalled valid_out: got %b want 0", i, valid_out); end
        end
      end
      total++; if (n != 33) begin bad++; $display("FAIL mul[%0d] stall_cycles: got %0d want 33", i, n); end
      total++; if (hi_out !== p[63:32] || lo_out !== p[31:0]) begin
        bad++; $display("FAIL mul[%0d] hilo: got %h/%h want %h/%h", i, hi_out, lo_out, p[63:32], p[31:0]); end
      mdl_hi = p[63:32]; mdl_lo = p[31:0];
      tick();
      total++; if (valid_out !== 1'b1 || reg_write_out !== 1'b0) begin
        bad++; $display("FAIL mul[%0d] retire: got valid=%b wr=%b want 1/0", i, valid_out, reg_write_out); end
      drive(1'b1, rtype(5'd0, 5'd0, 5'd9, 5'd0, 6'h10), 32'd0, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (ALU_out !== mdl_hi || reg_write_out !== 1'b1) begin
        bad++; $display("FAIL mul[%0d] mfhi: got %h wr=%b want %h wr=1", i, ALU_out, reg_write_out, mdl_hi); end
      drive(1'b1, rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h12), 32'd0, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (ALU_out !== mdl_lo) begin bad++; $display("FAIL mul[%0d] mflo: got %h want %h", i, ALU_out, mdl_lo); end
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL mul[%0d] post stall_out: got %b want 0", i, stall_out); end
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), 32'd3, 32'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL rstmul busy stall_out: got %b want 1", stall_out); end
    reset = 1'b1;
    valid_in = 1'b0;
    tick();
    reset = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    total++; if (stall_out !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL rstmul after: got stall=%b valid=%b want 0/0", stall_out, valid_out); end
    total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      bad++; $display("FAIL rstmul hilo: got %h/%h want 0/0", hi_out, lo_out); end
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rstmul add stall_out: got %b want 0", stall_out); end
    tick();
    total++; if (valid_out !== 1'b1 || ALU_out !== 32'd12 || reg_write_out !== 1'b1 || dest_out !== 5'd3) begin
      bad++; $display("FAIL rstmul add: got v=%b alu=%h wr=%b d=%0d want 1/0000000c/1/3", valid_out, ALU_out, reg_write_out, dest_out); end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_random();
    test_multu();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
